cpu_execute: RTL and testbench

CPU_EXECUTE -- requirements
Module: cpu_execute

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_alu.sv | 40 ++++
 rtl/cpu_execute.sv | 162 ++++++++++++++++
 tb/tb_cpu_execute.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, execute skid-buffer states and
// the payload carried by each buffered execute result.
package cpu_pkg;

  localparam int TAG_W_DEF = 4;

  localparam logic [3:0] OP_SADD = 4'd0;
  localparam logic [3:0] OP_UADD = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_NE   = 4'd12;
  localparam logic [3:0] OP_SGE  = 4'd13;
  localparam logic [3:0] OP_SGEU = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        taken;
    logic [31:0] target;
  } exe_entry_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic result, shifter result and a single
// compare bit, each valid only for its own group of op codes.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [3:0]  i_op,
  output logic [31:0] o_main,
  output logic [31:0] o_shift,
  output logic        o_cmp
);

  logic [4:0] shamt;
  assign shamt = i_op2[4:0];

  always_comb begin
    o_main  = '0;
    o_shift = '0;
    o_cmp   = 1'b0;
    case (i_op)
      OP_SADD, OP_UADD: o_main  = i_op1 + i_op2;
      OP_SUB:           o_main  = i_op1 - i_op2;
      OP_AND:           o_main  = i_op1 & i_op2;
      OP_OR:            o_main  = i_op1 | i_op2;
      OP_XOR:           o_main  = i_op1 ^ i_op2;
      OP_SLL:           o_shift = i_op1 << shamt;
      OP_SRL:           o_shift = i_op1 >> shamt;
      OP_SRA:           o_shift = $unsigned($signed(i_op1) >>> shamt);
      OP_SLT:           o_cmp   = $signed(i_op1) < $signed(i_op2);
      OP_SLTU:          o_cmp   = i_op1 < i_op2;
      OP_EQ:            o_cmp   = i_op1 == i_op2;
      OP_NE:            o_cmp   = i_op1 != i_op2;
      OP_SGE:           o_cmp   = $signed(i_op1) >= $signed(i_op2);
      OP_SGEU:          o_cmp   = i_op1 >= i_op2;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_execute.sv
// Execute stage: computes ALU/branch/jump results and holds them in a
// 2-entry skid buffer between decode and the memory stage.
module cpu_execute
  import cpu_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
)
(
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [31:0]      i_imm,
  input  logic [3:0]       i_op,
  input  logic             i_op2_imm,
  input  logic             i_is_branch,
  input  logic             i_is_jump,
  input  logic [4:0]       i_rd,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [4:0]       o_rd,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_branch_taken,
  output logic [31:0]      o_branch_target
);

  logic [31:0] op2;
  logic [31:0] alu_main;
  logic [31:0] alu_shift;
  logic        alu_cmp;
  logic [31:0] pc_target;
  exe_entry_t  new_entry;

  assign op2       = i_op2_imm ? i_imm : i_rs2;
  assign pc_target = i_pc + i_imm;

  cpu_alu u_alu (
    .i_op1   (i_rs1),
    .i_op2   (op2),
    .i_op    (i_op),
    .o_main  (alu_main),
    .o_shift (alu_shift),
    .o_cmp   (alu_cmp)
  );

  always_comb begin
    new_entry    = '0;
    new_entry.rd = i_rd;
    if (i_op <= OP_XOR) begin
      new_entry.result = alu_main;
    end else if (i_op <= OP_SRA) begin
      new_entry.result = alu_shift;
    end else if (i_op <= OP_SGEU) begin
      new_entry.result = {31'b0, alu_cmp};
    end
    if (i_is_jump) begin
      new_entry.result = i_pc + 32'd4;
      new_entry.taken  = 1'b1;
      new_entry.target = pc_target;
    end else if (i_is_branch) begin
      new_entry.result = '0;
      new_entry.rd     = '0;
      new_entry.taken  = alu_cmp;
      new_entry.target = pc_target;
    end
    // The reserved op code silently produces nothing rather than trapping.
    if (i_op == OP_RSVD) begin
      new_entry.result = '0;
      new_entry.taken  = 1'b0;
    end
  end

  skid_state_t      state_q, state_d;
  logic             ready_q, ready_d;
  exe_entry_t       ent0_q, ent0_d, ent1_q, ent1_d;
  logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic             accept;
  logic             drain;

  assign accept = i_valid && ready_q;
  assign drain  = (state_q != ST_EMPTY) && i_ready;

  // Entry 0 is always the oldest; entry 1 only fills while entry 0 is stalled.
  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      ent0_d  = '0;
      ent1_d  = '0;
      tag0_d  = '0;
      tag1_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            ent0_d  = new_entry;
            tag0_d  = i_tag;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            ent0_d = new_entry;
            tag0_d = i_tag;
          end else if (accept) begin
            state_d = ST_FULL;
            ent1_d  = new_entry;
            tag1_d  = i_tag;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d = ST_ONE;
            ent0_d  = ent1_q;
            tag0_d  = tag1_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
    end
  end

  assign o_valid         = (state_q != ST_EMPTY);
  assign o_ready         = ready_q;
  assign o_result        = o_valid ? ent0_q.result : '0;
  assign o_rd            = o_valid ? ent0_q.rd : '0;
  assign o_tag           = o_valid ? tag0_q : '0;
  assign o_branch_taken  = o_valid ? ent0_q.taken : 1'b0;
  assign o_branch_target = o_valid ? ent0_q.target : '0;

endmodule

// File: tb/tb_cpu_execute.sv
// Bench for cpu_execute: directed scenarios plus a randomized run checked
// against a queue-based behavioural model of the execute stage.
module tb_cpu_execute;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_tag;
  logic [31:0] i_pc, i_rs1, i_rs2, i_imm;
  logic [3:0]  i_op;
  logic        i_op2_imm, i_is_branch, i_is_jump;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic [3:0]  o_tag;
  logic        o_branch_taken;
  logic [31:0] o_branch_target;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic [3:0]  tag;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t q[$];
  logic ready_m;

  cpu_execute #(.TAG_W(4)) dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_tag           (i_tag),
    .i_pc            (i_pc),
    .i_rs1           (i_rs1),
    .i_rs2           (i_rs2),
    .i_imm           (i_imm),
    .i_op            (i_op),
    .i_op2_imm       (i_op2_imm),
    .i_is_branch     (i_is_branch),
    .i_is_jump       (i_is_jump),
    .i_rd            (i_rd),
    .i_flush         (i_flush),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_result        (o_result),
    .o_rd            (o_rd),
    .o_tag           (o_tag),
    .o_branch_taken  (o_branch_taken),
    .o_branch_target (o_branch_target)
  );

  always #5 i_clock = ~i_clock;

  // Expected result written straight from the op table, not from the RTL.
  function automatic exp_t ref_exec(input logic [3:0] op, input logic [31:0] pc,
                                    input logic [31:0] rs1, input logic [31:0] rs2,
                                    input logic [31:0] imm, input logic op2_imm,
                                    input logic br, input logic jmp,
                                    input logic [4:0] rd, input logic [3:0] tag);
    exp_t e;
    logic [31:0] b;
    logic cmp;
    b   = op2_imm ? imm : rs2;
    cmp = 1'b0;
    e   = '0;
    e.rd  = rd;
    e.tag = tag;
    case (op)
      4'd0, 4'd1: e.result = rs1 + b;
      4'd2:  e.result = rs1 - b;
      4'd3:  e.result = rs1 & b;
      4'd4:  e.result = rs1 | b;
      4'd5:  e.result = rs1 ^ b;
      4'd6:  e.result = rs1 << b[4:0];
      4'd7:  e.result = rs1 >> b[4:0];
      4'd8:  e.result = 32'($signed(rs1) >>> b[4:0]);
      4'd9:  cmp = $signed(rs1) < $signed(b);
      4'd10: cmp = rs1 < b;
      4'd11: cmp = rs1 == b;
      4'd12: cmp = rs1 != b;
      4'd13: cmp = $signed(rs1) >= $signed(b);
      4'd14: cmp = rs1 >= b;
      default: e.result = '0;
    endcase
    if (op >= 4'd9 && op <= 4'd14) e.result = {31'b0, cmp};
    if (jmp) begin
      e.result = pc + 32'd4;
      e.taken  = 1'b1;
      e.target = pc + imm;
    end else if (br) begin
      e.result = '0;
      e.rd     = '0;
      e.taken  = cmp;
      e.target = pc + imm;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    i_valid = 0; i_tag = 0; i_pc = 0; i_rs1 = 0; i_rs2 = 0; i_imm = 0;
    i_op = 0; i_op2_imm = 0; i_is_branch = 0; i_is_jump = 0; i_rd = 0;
    i_flush = 0;
  endtask

  task automatic drive_insn(input logic [3:0] tag, input logic [3:0] op,
                            input logic [31:0] pc, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm,
                            input logic op2_imm, input logic br, input logic jmp,
                            input logic [4:0] rd);
    i_valid = 1; i_tag = tag; i_op = op; i_pc = pc; i_rs1 = rs1; i_rs2 = rs2;
    i_imm = imm; i_op2_imm = op2_imm; i_is_branch = br; i_is_jump = jmp; i_rd = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_ready   = 0;
    i_reset_n = 0;
    repeat (2) @(negedge i_clock);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_result !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: valid=%b ready=%b result=%h, required 0 0 0", o_valid, o_ready, o_result);
    end
    i_reset_n = 1;
    #1;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ready_before_edge: got %b required 0", o_ready);
    end
    @(negedge i_clock);
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ready_after_release: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
    // Fill both entries, then pull reset in the middle of the cycle.
    drive_insn(4'd1, 4'd0, 0, 32'd1, 32'd2, 0, 0, 0, 0, 5'd3);
    @(negedge i_clock);
    drive_insn(4'd2, 4'd0, 0, 32'd3, 32'd4, 0, 0, 0, 0, 5'd4);
    @(negedge i_clock);
    clear_inputs();
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_tag !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL full_before_reset: ready=%b valid=%b tag=%h required 0 1 1", o_ready, o_valid, o_tag);
    end
    #2 i_reset_n = 0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_tag !== 4'd0 || o_result !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: valid=%b ready=%b tag=%h result=%h required 0 0 0 0",
               o_valid, o_ready, o_tag, o_result);
    end
    @(negedge i_clock);
    i_reset_n = 1;
    i_ready   = 1;
    @(negedge i_clock);
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ready_after_mid_reset: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_sub();
    i_ready = 1;
    drive_insn(4'd3, 4'd2, 0, 32'd5, 32'd7, 0, 0, 0, 0, 5'd9);
    @(negedge i_clock);
    clear_inputs();
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFE || o_rd !== 5'd9 || o_tag !== 4'd3
        || o_branch_taken !== 1'b0 || o_branch_target !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL sub: valid=%b result=%h rd=%0d tag=%h taken=%b target=%h required 1 fffffffe 9 3 0 0",
               o_valid, o_result, o_rd, o_tag, o_branch_taken, o_branch_target);
    end
    @(negedge i_clock);
    n_checks++;
    if (o_valid !== 1'b0 || o_result !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL sub_one_cycle: valid=%b result=%h required 0 0", o_valid, o_result);
    end
  endtask

  task automatic test_sra();
    i_ready = 1;
    drive_insn(4'd4, 4'd8, 0, 32'h8000_0000, 32'd31, 32'd4, 1, 0, 0, 5'd2);
    @(negedge i_clock);
    clear_inputs();
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== 32'hF800_0000) begin
      n_fail++;
      $display("[TB] FAIL sra_imm: valid=%b result=%h required 1 f8000000", o_valid, o_result);
    end
    @(negedge i_clock);
  endtask

  task automatic test_branch_jump();
    i_ready = 1;
    drive_insn(4'd5, 4'd9, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 0, 1, 0, 5'd7);
    @(negedge i_clock);
    n_checks++;
    if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h0000_00F0 || o_rd !== 5'd0
        || o_result !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL branch_slt: taken=%b target=%h rd=%0d result=%h required 1 f0 0 0",
               o_branch_taken, o_branch_target, o_rd, o_result);
    end
    drive_insn(4'd6, 4'd0, 32'h200, 32'd9, 32'd9, 32'h40, 0, 0, 1, 5'd1);
    @(negedge i_clock);
    n_checks++;
    if (o_result !== 32'h204 || o_branch_taken !== 1'b1 || o_branch_target !== 32'h240 || o_rd !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL jump: result=%h taken=%b target=%h rd=%0d required 204 1 240 1",
               o_result, o_branch_taken, o_branch_target, o_rd);
    end
    drive_insn(4'd7, 4'd15, 32'h300, 32'd5, 32'd6, 32'd1, 0, 0, 0, 5'd2);
    @(negedge i_clock);
    clear_inputs();
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== 32'h0 || o_branch_taken !== 1'b0 || o_tag !== 4'd7) begin
      n_fail++;
      $display("[TB] FAIL op15: valid=%b result=%h taken=%b tag=%h required 1 0 0 7",
               o_valid, o_result, o_branch_taken, o_tag);
    end
    @(negedge i_clock);
  endtask

  task automatic test_back_pressure();
    i_ready = 0;
    drive_insn(4'd1, 4'd0, 0, 32'd1, 32'd1, 0, 0, 0, 0, 5'd1);
    @(negedge i_clock);
    drive_insn(4'd2, 4'd0, 0, 32'd2, 32'd2, 0, 0, 0, 0, 5'd2);
    @(negedge i_clock);
    n_checks++;
    if (o_ready !== 1'b0 || o_tag !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL bp_full: ready=%b tag=%h required 0 1", o_ready, o_tag);
    end
    drive_insn(4'd3, 4'd0, 0, 32'd3, 32'd3, 0, 0, 0, 0, 5'd3);
    @(negedge i_clock);
    n_checks++;
    if (o_ready !== 1'b0 || o_tag !== 4'd1 || o_result !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL bp_stable: ready=%b tag=%h result=%h required 0 1 2", o_ready, o_tag, o_result);
    end
    i_ready = 1;
    @(negedge i_clock);
    n_checks++;
    if (o_tag !== 4'd2 || o_ready !== 1'b1 || o_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_second: tag=%h ready=%b valid=%b required 2 1 1", o_tag, o_ready, o_valid);
    end
    @(negedge i_clock);
    clear_inputs();
    n_checks++;
    if (o_tag !== 4'd3 || o_result !== 32'd6 || o_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_third: tag=%h result=%h valid=%b required 3 6 1", o_tag, o_result, o_valid);
    end
    @(negedge i_clock);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_drained: valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_flush();
    logic seen;
    i_ready = 0;
    drive_insn(4'd4, 4'd1, 0, 32'd1, 32'd1, 0, 0, 0, 0, 5'd1);
    @(negedge i_clock);
    drive_insn(4'd5, 4'd1, 0, 32'd1, 32'd1, 0, 0, 0, 0, 5'd1);
    @(negedge i_clock);
    drive_insn(4'd6, 4'd1, 0, 32'd1, 32'd1, 0, 0, 0, 0, 5'd1);
    i_flush = 1;
    @(negedge i_clock);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_tag !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL flush_full: valid=%b ready=%b tag=%h required 0 1 0", o_valid, o_ready, o_tag);
    end
    // Flush while an accept is possible: the same-cycle instruction is dropped too.
    i_flush = 0;
    drive_insn(4'd7, 4'd1, 0, 32'd1, 32'd1, 0, 0, 0, 0, 5'd1);
    @(negedge i_clock);
    drive_insn(4'd8, 4'd1, 0, 32'd1, 32'd1, 0, 0, 0, 0, 5'd1);
    i_flush = 1;
    i_ready = 1;
    @(negedge i_clock);
    clear_inputs();
    seen = o_valid;
    repeat (4) begin
      @(negedge i_clock);
      seen = seen | o_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_dropped: flushed entry reappeared (valid seen=%b) required 0", seen);
    end
  endtask

  task automatic test_random();
    logic drain_m, acc_m;
    exp_t exp_out, got;
    q.delete();
    ready_m = 1'b1;
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      i_valid   = ($urandom_range(0, 9) < 6);
      i_ready   = ($urandom_range(0, 9) < 6);
      i_flush   = ($urandom_range(0, 24) == 0);
      i_tag     = 4'($urandom);
      i_op      = 4'($urandom);
      i_pc      = $urandom;
      i_rs1     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      i_rs2     = ($urandom_range(0, 3) == 0) ? i_rs1 : $urandom;
      i_imm     = $urandom;
      i_op2_imm = 1'($urandom);
      i_rd      = 5'($urandom);
      case ($urandom_range(0, 9))
        0, 1: i_is_branch = 1;
        2:    i_is_jump   = (i_op != 4'd15);
        default: ;
      endcase
      @(posedge i_clock);
      drain_m = (q.size() > 0) && i_ready;
      acc_m   = i_valid && ready_m;
      if (i_flush) begin
        q.delete();
      end else begin
        if (drain_m) void'(q.pop_front());
        if (acc_m) q.push_back(ref_exec(i_op, i_pc, i_rs1, i_rs2, i_imm, i_op2_imm,
                                        i_is_branch, i_is_jump, i_rd, i_tag));
      end
      ready_m = (q.size() < 2);
      @(negedge i_clock);
      n_checks++;
      if (o_valid !== (q.size() > 0) || o_ready !== ready_m) begin
        n_fail++;
        $display("[TB] FAIL rand_handshake cycle %0d: valid=%b ready=%b required %b %b",
                 c, o_valid, o_ready, (q.size() > 0), ready_m);
      end
      exp_out = (q.size() > 0) ? q[0] : '0;
      got     = {o_result, o_rd, o_tag, o_branch_taken, o_branch_target};
      n_checks++;
      if (got !== exp_out) begin
        n_fail++;
        $display("[TB] FAIL rand_payload cycle %0d: got res=%h rd=%0d tag=%h tk=%b tgt=%h required res=%h rd=%0d tag=%h tk=%b tgt=%h",
                 c, got.result, got.rd, got.tag, got.taken, got.target,
                 exp_out.result, exp_out.rd, exp_out.tag, exp_out.taken, exp_out.target);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_sra();
    test_branch_jump();
    test_back_pressure();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
